// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the multi-cycle CPU control path.
//   - opcode / funct constants
//   - 4-bit controller state enum
//   - alu_src_b, pcsource, alu_op and alu_ctrl encodings
package cpu_pkg;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// alu_dec: combinational ALU control decoder.
//   alu_op   in  2 : 00 add, 01 sub, 10 decode from funct
//   funct    in  6 : instruction funct field
//   alu_ctrl out 3 : ALU operation select
//   funct_ok out 1 : funct is a supported R-type operation (1 when not decoding funct)
module alu_dec
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_ok
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    funct_ok = 1'b1;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: funct_ok = 1'b0;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU control unit.
// Inputs : clk, rst (async, active-low), opcode/funct from IR, ALU zero, mem_ready.
// Outputs: datapath controls (write_pc, pcsource, i_or_d, mem_read, mem_write,
//          write_ir, reg_dst, mem_to_reg, write_reg, alu_src_a, alu_src_b,
//          alu_ctrl), sticky illegal_op, and debug state.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC once memory is ready
// DECODE | branch target -> ALUOut, dispatch on opcode
// MEMADR | base + imm address for LW/SW
// MEMRD  | data read, wait for mem_ready
// MEMWB  | MDR -> rt
// MEMWR  | data write, wait for mem_ready
// EXEC   | R-type ALU operation
// RWB    | ALUOut -> rd
// BRANCH | compare A/B, take branch on zero
// JUMP   | jump address -> PC
// ADDIEX | A + imm
// ADDIWB | ALUOut -> rt
module mc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [5:0] OP_R    = OPC_R,
  parameter logic [5:0] OP_LW   = OPC_LW,
  parameter logic [5:0] OP_SW   = OPC_SW,
  parameter logic [5:0] OP_BEQ  = OPC_BEQ,
  parameter logic [5:0] OP_J    = OPC_J,
  parameter logic [5:0] OP_ADDI = OPC_ADDI
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       write_pc,
  output logic [1:0] pcsource,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       write_ir,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       write_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [1:0] alu_op;
  logic [2:0] dec_ctrl;
  logic       funct_ok;

  logic       wpc_c, iord_c, mr_c, mw_c, wir_c, rd_c, m2r_c, wr_c, asa_c;
  logic [1:0] pcs_c, asb_c;

  alu_dec u_alu_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .funct_ok (funct_ok)
  );

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    alu_op    = ALUOP_ADD;
    wpc_c     = 1'b0;
    pcs_c     = PCSRC_ALU;
    iord_c    = 1'b0;
    mr_c      = 1'b0;
    mw_c      = 1'b0;
    wir_c     = 1'b0;
    rd_c      = 1'b0;
    m2r_c     = 1'b0;
    wr_c      = 1'b0;
    asa_c     = 1'b0;
    asb_c     = SRCB_REGB;
    case (state_q)
      S_FETCH: begin
        mr_c  = 1'b1;
        asb_c = SRCB_FOUR;
        if (mem_ready) begin
          wir_c   = 1'b1;
          wpc_c   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        asb_c = SRCB_IMM_SH;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_R)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else                                    illegal_d = 1'b1;
      end
      S_MEMADR: begin
        asa_c = 1'b1;
        asb_c = SRCB_IMM;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD: begin
        mr_c    = 1'b1;
        iord_c  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        wr_c  = 1'b1;
        m2r_c = 1'b1;
      end
      S_MEMWR: begin
        mw_c    = 1'b1;
        iord_c  = 1'b1;
        state_d = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        asa_c  = 1'b1;
        alu_op = ALUOP_FUNCT;
        if (funct_ok) state_d = S_RWB;
        else          illegal_d = 1'b1;
      end
      S_RWB: begin
        wr_c = 1'b1;
        rd_c = 1'b1;
      end
      S_BRANCH: begin
        asa_c  = 1'b1;
        alu_op = ALUOP_SUB;
        pcs_c  = PCSRC_ALUOUT;
        wpc_c  = zero;
      end
      S_JUMP: begin
        wpc_c = 1'b1;
        pcs_c = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        asa_c   = 1'b1;
        asb_c   = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: wr_c = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Gating with rst kills FETCH's mem_read and any in-flight strobe the
  // moment reset falls, without waiting for a clock.
  assign write_pc   = rst & wpc_c;
  assign pcsource   = rst ? pcs_c : 2'b00;
  assign i_or_d     = rst & iord_c;
  assign mem_read   = rst & mr_c;
  assign mem_write  = rst & mw_c;
  assign write_ir   = rst & wir_c;
  assign reg_dst    = rst & rd_c;
  assign mem_to_reg = rst & m2r_c;
  assign write_reg  = rst & wr_c;
  assign alu_src_a  = rst & asa_c;
  assign alu_src_b  = rst ? asb_c : 2'b00;
  assign alu_ctrl   = rst ? dec_ctrl : ALU_ADD;
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven bench for mc_ctrl plus hand-written reset and
// illegal-opcode sequences.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       write_pc, i_or_d, mem_read, mem_write, write_ir;
  logic       reg_dst, mem_to_reg, write_reg, alu_src_a, illegal_op;
  logic [1:0] pcsource, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic [16:0] act_ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .write_pc   (write_pc),
    .pcsource   (pcsource),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write_ir   (write_ir),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .write_reg  (write_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .illegal_op (illegal_op),
    .state      (state)
  );

  assign act_ctl = {write_pc, pcsource, i_or_d, mem_read, mem_write, write_ir,
                    reg_dst, mem_to_reg, write_reg, alu_src_a, alu_src_b,
                    alu_ctrl, illegal_op};

  typedef struct {
    string       tag;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [16:0] exp_ctl;
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] J = 6'b000010, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, RT = 6'b000000, ADDI = 6'b001000;

  function automatic logic [16:0] ctl(
    input logic wpc, input logic [1:0] pcs, input logic iord, input logic mr,
    input logic mw, input logic wir, input logic rd, input logic m2r,
    input logic wr, input logic asa, input logic [1:0] asb,
    input logic [2:0] alu, input logic ill);
    return {wpc, pcs, iord, mr, mw, wir, rd, m2r, wr, asa, asb, alu, ill};
  endfunction

  function automatic logic [16:0] f_go(input logic ill);
    return ctl(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, ill);
  endfunction
  function automatic logic [16:0] f_wait(input logic ill);
    return ctl(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, ill);
  endfunction
  function automatic logic [16:0] f_dec(input logic ill);
    return ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, ill);
  endfunction

  task automatic add(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] st,
                     input logic [16:0] c);
    vec_t v;
    v.tag = tag; v.opcode = op; v.funct = fn; v.zero = z; v.mem_ready = mr;
    v.exp_state = st; v.exp_ctl = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic strobes_zero(input string name);
    chk({name, "_strobes"}, {28'd0, write_pc, write_ir, write_reg, mem_write}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // J: 0 -> 1 -> 9
    add("j_fetch", J, 6'd0, 0, 1, 4'd0, f_go(0));
    add("j_dec",   J, 6'd0, 0, 1, 4'd1, f_dec(0));
    add("j_jump",  J, 6'd0, 0, 1, 4'd9, ctl(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0));
    // LW with two wait cycles in MEMRD
    add("lw_fetch", LW, 6'd0, 0, 1, 4'd0, f_go(0));
    add("lw_dec",   LW, 6'd0, 0, 1, 4'd1, f_dec(0));
    add("lw_madr",  LW, 6'd0, 0, 0, 4'd2, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0));
    add("lw_rd_w0", LW, 6'd0, 0, 0, 4'd3, ctl(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0));
    add("lw_rd_w1", LW, 6'd0, 0, 0, 4'd3, ctl(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0));
    add("lw_rd_ok", LW, 6'd0, 0, 1, 4'd3, ctl(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0));
    add("lw_wb",    LW, 6'd0, 0, 1, 4'd4, ctl(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 0));
    // SW with one wait cycle in MEMWR
    add("sw_fetch", SW, 6'd0, 0, 1, 4'd0, f_go(0));
    add("sw_dec",   SW, 6'd0, 0, 1, 4'd1, f_dec(0));
    add("sw_madr",  SW, 6'd0, 0, 1, 4'd2, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0));
    add("sw_wr_w",  SW, 6'd0, 0, 0, 4'd5, ctl(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0));
    add("sw_wr_ok", SW, 6'd0, 0, 1, 4'd5, ctl(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0));
    // BEQ taken
    add("beq1_fetch", BEQ, 6'd0, 1, 1, 4'd0, f_go(0));
    add("beq1_dec",   BEQ, 6'd0, 1, 1, 4'd1, f_dec(0));
    add("beq1_br",    BEQ, 6'd0, 1, 1, 4'd8, ctl(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0));
    // BEQ not taken, preceded by a fetch wait
    add("beq0_fwait", BEQ, 6'd0, 0, 0, 4'd0, f_wait(0));
    add("beq0_fetch", BEQ, 6'd0, 0, 1, 4'd0, f_go(0));
    add("beq0_dec",   BEQ, 6'd0, 0, 1, 4'd1, f_dec(0));
    add("beq0_br",    BEQ, 6'd0, 0, 1, 4'd8, ctl(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0));
    // R-type sub / and / or / slt
    add("sub_fetch", RT, 6'b100010, 0, 1, 4'd0, f_go(0));
    add("sub_dec",   RT, 6'b100010, 0, 1, 4'd1, f_dec(0));
    add("sub_exec",  RT, 6'b100010, 0, 1, 4'd6, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0));
    add("sub_rwb",   RT, 6'b100010, 0, 1, 4'd7, ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 0));
    add("and_fetch", RT, 6'b100100, 0, 1, 4'd0, f_go(0));
    add("and_dec",   RT, 6'b100100, 0, 1, 4'd1, f_dec(0));
    add("and_exec",  RT, 6'b100100, 0, 1, 4'd6, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 0));
    add("and_rwb",   RT, 6'b100100, 0, 1, 4'd7, ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 0));
    add("or_fetch",  RT, 6'b100101, 0, 1, 4'd0, f_go(0));
    add("or_dec",    RT, 6'b100101, 0, 1, 4'd1, f_dec(0));
    add("or_exec",   RT, 6'b100101, 0, 1, 4'd6, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0));
    add("or_rwb",    RT, 6'b100101, 0, 1, 4'd7, ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 0));
    add("slt_fetch", RT, 6'b101010, 0, 1, 4'd0, f_go(0));
    add("slt_dec",   RT, 6'b101010, 0, 1, 4'd1, f_dec(0));
    add("slt_exec",  RT, 6'b101010, 0, 1, 4'd6, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 0));
    add("slt_rwb",   RT, 6'b101010, 0, 1, 4'd7, ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 0));
    // ADDI
    add("addi_fetch", ADDI, 6'd0, 0, 1, 4'd0,  f_go(0));
    add("addi_dec",   ADDI, 6'd0, 0, 1, 4'd1,  f_dec(0));
    add("addi_ex",    ADDI, 6'd0, 0, 1, 4'd10, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0));
    add("addi_wb",    ADDI, 6'd0, 0, 1, 4'd11, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 0));
    // R-type with unsupported funct: abort from EXEC, no RWB, sticky flag
    add("badfn_fetch", RT, 6'b000011, 0, 1, 4'd0, f_go(0));
    add("badfn_dec",   RT, 6'b000011, 0, 1, 4'd1, f_dec(0));
    add("badfn_exec",  RT, 6'b000011, 0, 1, 4'd6, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0));
    add("badfn_after", J,  6'd0,      0, 1, 4'd0, f_go(1));

    // Reset: outputs forced low even with mem_ready high
    mem_ready = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_ctl", {15'd0, act_ctl}, {15'd0, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0)});
    rst = 1'b1;

    foreach (vecs[i]) begin
      opcode    = vecs[i].opcode;
      funct     = vecs[i].funct;
      zero      = vecs[i].zero;
      mem_ready = vecs[i].mem_ready;
      #1;
      chk({vecs[i].tag, "_state"}, {28'd0, state}, {28'd0, vecs[i].exp_state});
      chk({vecs[i].tag, "_ctl"}, {15'd0, act_ctl}, {15'd0, vecs[i].exp_ctl});
      @(negedge clk);
    end

    // Illegal opcode: flag after DECODE, no strobes, cleared by reset
    rst = 1'b0;
    @(negedge clk);
    chk("ill_reset_clr", {31'd0, illegal_op}, 32'd0);
    rst = 1'b1;
    opcode = 6'b111111; funct = 6'd0; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("ill_dec_state", {28'd0, state}, 32'd1);
    strobes_zero("ill_dec");
    chk("ill_dec_flag", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("ill_after_state", {28'd0, state}, 32'd0);
    chk("ill_after_flag", {31'd0, illegal_op}, 32'd1);
    strobes_zero("ill_after");
    @(negedge clk);
    chk("ill_sticky", {31'd0, illegal_op}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ill_cleared", {31'd0, illegal_op}, 32'd0);

    // Reset dropped in MEMWR while waiting: write strobe must die at once
    @(negedge clk);
    rst = 1'b1;
    opcode = SW; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("abort_pre_state", {28'd0, state}, 32'd5);
    chk("abort_pre_mw", {31'd0, mem_write}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_mw", {31'd0, mem_write}, 32'd0);
    chk("abort_state", {28'd0, state}, 32'd0);
    chk("abort_mr", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_hold_mw", {31'd0, mem_write}, 32'd0);
    rst = 1'b1;
    #1;
    chk("release_state", {28'd0, state}, 32'd0);
    chk("release_mr", {31'd0, mem_read}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
